// File: rtl/decode_cycle_if.sv
// Decode-stage bus: fetch/writeback inputs in, D/E pipeline register contents out.
// The master drives the instruction and writeback side; the slave (decode) drives the E-stage fields.
interface decode_cycle_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;

    logic        RegWriteE;
    logic        ALUSrcE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RD_E;
    logic [4:0]  RS1_E;
    logic [4:0]  RS2_E;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW,
        input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
        input  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW,
        output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
        output RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E
    );
endinterface

// File: rtl/decode_cycle.sv
// RV32 decode stage: control decode, immediate extension and 32x32 register file into a D/E register.
// One-cycle latency from InstrD to E outputs; no backpressure, the pipeline advances every edge.
module decode_cycle (
    input  logic          clk,
    input  logic          rst,
    decode_cycle_if.slave bus
);
    typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} immSrc_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign opcode   = bus.InstrD[6:0];
    assign funct3   = bus.InstrD[14:12];
    assign funct7b5 = bus.InstrD[30];
    assign rs1      = bus.InstrD[19:15];
    assign rs2      = bus.InstrD[24:20];
    assign rd       = bus.InstrD[11:7];

    logic        regWrite;
    logic        aluSrc;
    logic        memWrite;
    logic        resultSrc;
    logic        branch;
    logic [1:0]  aluOp;
    immSrc_t     immSrc;
    logic [2:0]  aluCtl;
    logic [31:0] immExt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] rf [32];

    always_comb begin
        regWrite  = 1'b0;
        aluSrc    = 1'b0;
        memWrite  = 1'b0;
        resultSrc = 1'b0;
        branch    = 1'b0;
        aluOp     = 2'b00;
        immSrc    = IMM_NONE;
        case (opcode)
            OP_LW: begin
                regWrite  = 1'b1;
                aluSrc    = 1'b1;
                resultSrc = 1'b1;
                immSrc    = IMM_I;
            end
            OP_SW: begin
                memWrite = 1'b1;
                aluSrc   = 1'b1;
                immSrc   = IMM_S;
            end
            OP_R: begin
                regWrite = 1'b1;
                aluOp    = 2'b10;
            end
            OP_IALU: begin
                regWrite = 1'b1;
                aluSrc   = 1'b1;
                immSrc   = IMM_I;
                aluOp    = 2'b10;
            end
            OP_BEQ: begin
                branch = 1'b1;
                immSrc = IMM_B;
                aluOp  = 2'b01;
            end
            default: ;
        endcase
    end

    // Subtract only for R-type with funct7[5]; addi with imm[10] set must still add.
    always_comb begin
        aluCtl = 3'b000;
        case (aluOp)
            2'b01: aluCtl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  aluCtl = (opcode[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  aluCtl = 3'b101;
                    3'b110:  aluCtl = 3'b011;
                    3'b111:  aluCtl = 3'b010;
                    default: aluCtl = 3'b000;
                endcase
            end
            default: aluCtl = 3'b000;
        endcase
    end

    always_comb begin
        immExt = 32'd0;
        case (immSrc)
            IMM_I:   immExt = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
            IMM_S:   immExt = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
            IMM_B:   immExt = {{20{bus.InstrD[31]}}, bus.InstrD[7], bus.InstrD[30:25],
                               bus.InstrD[11:8], 1'b0};
            default: immExt = 32'd0;
        endcase
    end

    // Same-cycle writeback is forwarded so the read sees the value being written.
    always_comb begin
        rd1 = rf[rs1];
        rd2 = rf[rs2];
        if (rs1 == 5'd0)
            rd1 = 32'd0;
        else if (bus.RegWriteW && (bus.RdW == rs1))
            rd1 = bus.ResultW;
        if (rs2 == 5'd0)
            rd2 = 32'd0;
        else if (bus.RegWriteW && (bus.RdW == rs2))
            rd2 = bus.ResultW;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'd0;
        end else if (bus.RegWriteW && (bus.RdW != 5'd0)) begin
            rf[bus.RdW] <= bus.ResultW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.RegWriteE   <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.ResultSrcE  <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.ALUControlE <= 3'b000;
            bus.RD1_E       <= 32'd0;
            bus.RD2_E       <= 32'd0;
            bus.Imm_Ext_E   <= 32'd0;
            bus.PCE         <= 32'd0;
            bus.PCPlus4E    <= 32'd0;
            bus.RD_E        <= 5'd0;
            bus.RS1_E       <= 5'd0;
            bus.RS2_E       <= 5'd0;
        end else begin
            bus.RegWriteE   <= regWrite;
            bus.ALUSrcE     <= aluSrc;
            bus.MemWriteE   <= memWrite;
            bus.ResultSrcE  <= resultSrc;
            bus.BranchE     <= branch;
            bus.ALUControlE <= aluCtl;
            bus.RD1_E       <= rd1;
            bus.RD2_E       <= rd2;
            bus.Imm_Ext_E   <= immExt;
            bus.PCE         <= bus.PCD;
            bus.PCPlus4E    <= bus.PCPlus4D;
            bus.RD_E        <= rd;
            bus.RS1_E       <= rs1;
            bus.RS2_E       <= rs2;
        end
    end
endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
Parameters: none; widths fixed (XLEN 32, 32 architectural registers).
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-003 SHALL have ports InstrD/PCD/PCPlus4D  input  32 each  instruction, PC and PC+4 from the fetch pipeline register.
REQ-004 SHALL have ports RegWriteW (1), RdW (5), ResultW (32)  input  writeback enable, destination, data.
REQ-005 SHALL have control outputs RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE (1 each) and ALUControlE (3).
REQ-006 SHALL have data outputs RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E (32 each), and RD_E, RS1_E, RS2_E (5 each).

Function
REQ-007 SHALL register every output in a D/E pipeline register: one-cycle latency from InstrD/PCD/PCPlus4D to outputs; no combinational input-to-output path.
REQ-008 SHALL decode opcode: 0000011 lw (RegWrite=1, ALUSrc=1, ResultSrc=1, ImmSrc=I, ALUOp=00).
REQ-009 SHALL decode: 0100011 sw (MemWrite=1, ALUSrc=1, ImmSrc=S, ALUOp=00).
REQ-010 SHALL decode: 0110011 R-type (RegWrite=1, ALUOp=10) and 0010011 I-ALU (RegWrite=1, ALUSrc=1, ImmSrc=I, ALUOp=10).
REQ-011 SHALL decode: 1100011 beq (Branch=1, ImmSrc=B, ALUOp=01).
REQ-012 SHALL drive all controls 0 for any other opcode (bubble).
REQ-013 SHALL map ALUControl: ALUOp 00 -> 000 add; 01 -> 001 sub.
REQ-014 SHALL map ALUOp 10 via funct3: 000 -> 001 when op[5] & funct7[5], else 000; 010 -> 101 slt; 110 -> 011 or; 111 -> 010 and; any other -> 000.
REQ-015 SHALL sign-extend immediates from InstrD[31]: I = InstrD[31:20]; S = {InstrD[31:25], InstrD[11:7]}; B = {InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 0}.
REQ-016 SHALL drive Imm_Ext_E = 0 when the opcode selects no immediate.
REQ-017 SHALL pass InstrD[19:15] to RS1_E, InstrD[24:20] to RS2_E, InstrD[11:7] to RD_E, and PCD/PCPlus4D to PCE/PCPlus4E unchanged.
REQ-018 SHALL contain a 32x32 register file: asynchronous reads at InstrD[19:15] and InstrD[24:20]; synchronous write of ResultW to RdW on the rising edge when RegWriteW=1 and rst=1.
REQ-019 SHALL hard-wire x0: reads return 0; writes to RdW=0 are discarded.
REQ-020 SHALL bypass writes: when RegWriteW=1, RdW!=0, and RdW equals a read index in the same cycle, that read returns ResultW.
REQ-021 SHALL let a simultaneous write and pipeline advance both take effect on the same edge.

Reset
REQ-022 SHALL, on a rising edge with rst=0, clear all E outputs to 0 and all 32 registers to 0, regardless of other inputs.
REQ-023 SHALL suppress register-file writes on any edge with rst=0.
REQ-024 SHALL, after rst returns to 1, capture the first instruction on the next rising edge, with outputs valid one cycle later.
REQ-025 SHALL hold outputs and register file at their old values when rst is asserted between edges, until the next rising edge.

Verification
REQ-026 SHALL cover addi: InstrD=0x00A00293 -> next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=000, Imm_Ext_E=0x0000000A, RD_E=5, RD1_E=0.
REQ-027 SHALL cover sw: InstrD=0xFE612E23 -> MemWriteE=1, ALUSrcE=1, RegWriteE=0, Imm_Ext_E=0xFFFFFFFC, RS1_E=2, RS2_E=6.
REQ-028 SHALL cover beq: InstrD=0xFE208CE3 -> BranchE=1, ALUControlE=001, Imm_Ext_E=0xFFFFFFF8, RegWriteE=0.
REQ-029 SHALL cover bypass: RegWriteW=1, RdW=7, ResultW=0x12345678 with InstrD=0x00038433 in the same cycle -> RD1_E=0x12345678, RD_E=8.
REQ-030 SHALL cover x0: write RdW=0, ResultW=0xFFFFFFFF, then read x0 -> RD1_E=0.
REQ-031 SHALL cover reset mid-stream: write x5=0x55, assert rst=0 for one edge, then read x5 -> all E outputs 0 after the reset edge; x5 reads 0.
